bank_loader: RTL

BANK_LOADER -- requirements
Module: bank_loader

---
 rtl/bank_loader_pkg.sv | 8 +
 rtl/bank_loader.sv | 73 +++++++
 2 files changed

// File: rtl/bank_loader_pkg.sv
// bank_loader_pkg: shared bank geometry and loader FSM states for the filter and its bank writer
package bank_loader_pkg;
   localparam int NUM_BANKS = 16;
   localparam int DEPTH     = 4644;
   localparam int DW        = 8;
   localparam int AW        = 13;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
endpackage

// File: rtl/bank_loader.sv
// bank_loader: streams pixels into NUM_BANKS line-buffer banks, bank 0 first, DEPTH bytes each
// Ports: clk, rst_n (async, active-low), en (stall), start (load pulse),
//        in_valid/in_pixel/in_ready (source handshake),
//        wr_en (one-hot bank strobe), wr_addr, wr_data (shared bank write port), done (frame written)
module bank_loader #(
   parameter int NUM_BANKS = bank_loader_pkg::NUM_BANKS,
   parameter int DEPTH     = bank_loader_pkg::DEPTH,
   parameter int DW        = bank_loader_pkg::DW,
   parameter int AW        = bank_loader_pkg::AW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_pixel,
   output logic                 in_ready,
   output logic [NUM_BANKS-1:0] wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW-1:0]        wr_data,
   output logic                 done
);
   import bank_loader_pkg::*;
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   state_t                 state_q, state_d;
   logic [BW-1:0]          bank_q, bank_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [NUM_BANKS-1:0]   wr_en_q, wr_en_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic [DW-1:0]          wr_data_q, wr_data_d;
   logic                   xfer, last_addr, last_bank, begin_load;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bank_q    <= '0;
         addr_q    <= '0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (begin_load)
         state_d = LOAD;
      else if (xfer && last_addr && last_bank)
         state_d = DONE;
   end
   always_comb begin
      in_ready   = (state_q == LOAD) && en;
      done       = (state_q == DONE);
      xfer       = in_valid && in_ready;
      begin_load = en && start && (state_q != LOAD);
      last_addr  = (addr_q == AW'(DEPTH - 1));
      last_bank  = (bank_q == BW'(NUM_BANKS - 1));
      // Strobe is rebuilt every cycle, so any cycle without a transfer (including stalls) writes nothing
      wr_en_d    = xfer ? (NUM_BANKS'(1) << bank_q) : '0;
      wr_addr_d  = xfer ? addr_q : wr_addr_q;
      wr_data_d  = xfer ? in_pixel : wr_data_q;
      addr_d     = begin_load ? '0 : xfer ? (last_addr ? '0 : addr_q + 1'b1) : addr_q;
      bank_d     = begin_load ? '0 : (xfer && last_addr) ? bank_q + 1'b1 : bank_q;
      wr_en      = wr_en_q;
      wr_addr    = wr_addr_q;
      wr_data    = wr_data_q;
   end
endmodule
